// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmit and receive paths.
// Holds the transmitter state encoding, common command/response bytes,
// default cycle counts for a 50 MHz system clock and the parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_TX        = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // 100 us clock inhibit and 15 ms device-silence watchdog at 50 MHz
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;

  // PS/2 frames carry odd parity: the parity bit makes the 9-bit count of ones odd
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the asynchronous PS2_CLK / PS2_DAT pad levels into
// the clk domain and flags device clock falling edges.
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   ps2_clk_in/dat_in    raw pad levels
//   clk_sync/dat_sync    pad levels after two flops
//   clk_fe               one-cycle pulse: synchronised clock went 1 -> 0
// Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
module ps2_line_sync (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fe
);

  logic [1:0] clk_meta_r;
  logic [1:0] dat_meta_r;
  logic       clk_prev_r;

  // Two-stage synchronisers plus the previous synchronised clock level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_meta_r <= 2'b11;
      dat_meta_r <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_meta_r <= {clk_meta_r[0], ps2_clk_in};
      dat_meta_r <= {dat_meta_r[0], ps2_dat_in};
      clk_prev_r <= clk_meta_r[1];
    end
  end

  assign clk_sync = clk_meta_r[1];
  assign dat_sync = dat_meta_r[1];
  assign clk_fe   = clk_prev_r & ~clk_meta_r[1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter: sends one command byte from the host to a PS/2
// device: clock inhibit, request-to-send, 8 data bits LSB first, odd parity,
// stop, then samples the device acknowledge bit.
// Ports:
//   clk, resetn                 system clock, asynchronous active-low reset
//   send, send_data             one-cycle request and byte, taken when busy=0
//   ps2_clk_in, ps2_dat_in      raw pad levels (asynchronous)
//   ps2_clk_drive_low/dat_...   1 = pull the open-drain line low
//   busy                        frame in flight (gates the receive path)
//   done                        one-cycle end-of-frame pulse
//   ack_error, timeout          frame status, updated with done
// Optional feature: define PS2_TX_TIMEOUT_EN to build the device-silence
// watchdog; without it, timeout is always 0 and a silent device stalls TX.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       send,
  input  logic [7:0] send_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       timeout
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_host_transmitter: cycle counts out of range");
  end

  ps2_tx_state_e    state_r, state_nxt;
  logic [7:0]       data_r, data_nxt;
  logic             parity_r, parity_nxt;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_nxt;
  logic [3:0]       bit_cnt_r, bit_cnt_nxt;
  logic             ack_bit_r, ack_bit_nxt;
  logic             clk_dl_r, clk_dl_nxt;
  logic             dat_dl_r, dat_dl_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             ack_error_r, ack_error_nxt;
  logic             timeout_r, timeout_nxt;

  logic clk_sync_s;
  logic dat_sync_s;
  logic clk_fe_s;

  ps2_line_sync u_line_sync (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (clk_sync_s),
    .dat_sync   (dat_sync_s),
    .clk_fe     (clk_fe_s)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_r, wd_nxt;
  logic            wd_active_s;

  assign wd_active_s = (state_r == ST_TX) || (state_r == ST_ACK) ||
                       (state_r == ST_WAIT_IDLE);

  // Watchdog next value: cleared entering TX and on every device clock edge
  always_comb begin
    wd_nxt = wd_r;
    if (state_r == ST_RTS || clk_fe_s) begin
      wd_nxt = '0;
    end else if (wd_active_s) begin
      wd_nxt = wd_r + 1'b1;
    end else begin
      wd_nxt = '0;
    end
  end

  // Watchdog register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_r <= '0;
    end else begin
      wd_r <= wd_nxt;
    end
  end
`endif

  // Next-state and next-output logic; outputs are registered from *_nxt
  always_comb begin
    state_nxt     = state_r;
    data_nxt      = data_r;
    parity_nxt    = parity_r;
    inh_cnt_nxt   = inh_cnt_r;
    bit_cnt_nxt   = bit_cnt_r;
    ack_bit_nxt   = ack_bit_r;
    clk_dl_nxt    = clk_dl_r;
    dat_dl_nxt    = dat_dl_r;
    busy_nxt      = busy_r;
    done_nxt      = 1'b0;
    ack_error_nxt = ack_error_r;
    timeout_nxt   = timeout_r;

    case (state_r)
      ST_IDLE: begin
        clk_dl_nxt = 1'b0;
        dat_dl_nxt = 1'b0;
        if (send) begin
          data_nxt      = send_data;
          parity_nxt    = ps2_odd_parity(send_data);
          inh_cnt_nxt   = '0;
          clk_dl_nxt    = 1'b1;
          busy_nxt      = 1'b1;
          ack_error_nxt = 1'b0;
          timeout_nxt   = 1'b0;
          state_nxt     = ST_INHIBIT;
        end else begin
          busy_nxt = 1'b0;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_r == INH_LAST) begin
          dat_dl_nxt = 1'b1;  // start bit: request-to-send
          state_nxt  = ST_RTS;
        end else begin
          inh_cnt_nxt = inh_cnt_r + 1'b1;
        end
      end

      ST_RTS: begin
        clk_dl_nxt  = 1'b0;   // hand the clock to the device
        bit_cnt_nxt = 4'd0;
        state_nxt   = ST_TX;
      end

      ST_TX: begin
        // Each device falling edge presents the next bit; bit_cnt_r counts
        // edges already seen, so it selects the bit to put on the line now.
        if (clk_fe_s) begin
          bit_cnt_nxt = bit_cnt_r + 4'd1;
          case (bit_cnt_r)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
              dat_dl_nxt = ~data_r[bit_cnt_r[2:0]];
            end
            4'd8: begin
              dat_dl_nxt = ~parity_r;
            end
            default: begin
              dat_dl_nxt = 1'b0;  // stop bit is the released line
              state_nxt  = ST_ACK;
            end
          endcase
        end else begin
          bit_cnt_nxt = bit_cnt_r;
        end
      end

      ST_ACK: begin
        if (clk_fe_s) begin
          ack_bit_nxt = dat_sync_s;
          state_nxt   = ST_WAIT_IDLE;
        end else begin
          ack_bit_nxt = ack_bit_r;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync_s && dat_sync_s) begin
          done_nxt      = 1'b1;
          ack_error_nxt = ack_bit_r;
          timeout_nxt   = 1'b0;
          state_nxt     = ST_DONE;
        end else begin
          state_nxt = ST_WAIT_IDLE;
        end
      end

      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        clk_dl_nxt = 1'b0;
        dat_dl_nxt = 1'b0;
        busy_nxt   = 1'b0;
        state_nxt  = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // A silent device aborts the frame: release both lines and report
    if (wd_active_s && wd_r == WD_LAST) begin
      clk_dl_nxt    = 1'b0;
      dat_dl_nxt    = 1'b0;
      done_nxt      = 1'b1;
      ack_error_nxt = 1'b1;
      timeout_nxt   = 1'b1;
      state_nxt     = ST_DONE;
    end else begin
      timeout_nxt = timeout_nxt;
    end
`endif
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      data_r      <= 8'h00;
      parity_r    <= 1'b0;
      inh_cnt_r   <= '0;
      bit_cnt_r   <= 4'd0;
      ack_bit_r   <= 1'b0;
      clk_dl_r    <= 1'b0;
      dat_dl_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ack_error_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      data_r      <= data_nxt;
      parity_r    <= parity_nxt;
      inh_cnt_r   <= inh_cnt_nxt;
      bit_cnt_r   <= bit_cnt_nxt;
      ack_bit_r   <= ack_bit_nxt;
      clk_dl_r    <= clk_dl_nxt;
      dat_dl_r    <= dat_dl_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
      ack_error_r <= ack_error_nxt;
      timeout_r   <= timeout_nxt;
    end
  end

  assign ps2_clk_drive_low = clk_dl_r;
  assign ps2_dat_drive_low = dat_dl_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign ack_error         = ack_error_r;
  assign timeout           = timeout_r;

endmodule

// File: doc/ps2_host_transmitter.md
# ps2_host_transmitter

Host-to-device PS/2 transmitter: it sends one command byte (set-LEDs, reset, echo, and similar) from the FPGA to the keyboard. It runs the full handshake: clock inhibit, request-to-send, 10 host-driven bits clocked by the device, then the device acknowledge bit. It sits beside the existing PS/2 receive path and drives the PS2_CLK/PS2_DAT open-drain pads through drive-low enables. `busy` gates the receiver while a frame is in flight.

## Interface
- INHIBIT_CYCLES, 5000, cycles PS2_CLK is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum cycles without a device clock edge (15 ms at 50 MHz); used only with the timeout feature.
- clk  in  1  system clock (50 MHz).
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- send  in  1  one-cycle request; accepted only when busy=0.
- send_data  in  8  command byte; captured on the accepted send.
- ps2_clk_in  in  1  raw PS2_CLK pad level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pad level (asynchronous).
- ps2_clk_drive_low  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_drive_low  out  1  1 = pull PS2_DAT low; 0 = release.
- busy  out  1  high from the cycle after an accepted send until the cycle after done.
- done  out  1  one-cycle pulse marking the end of a frame.
- ack_error  out  1  valid with done; 1 = the device did not acknowledge.
- timeout  out  1  valid with done; 1 = the frame was aborted by the watchdog.

## Operation
- Synchronisation:
  - Both pad inputs pass through 2-flop synchronisers.
  - A falling edge (fe) is the previous synchronised clock = 1 and the current = 0.
- States:
  - **IDLE**: both drives 0. send → capture byte, compute odd parity (parity = ~^send_data), enter INHIBIT.
  - **INHIBIT**: clk_drive_low=1, dat_drive_low=0 for exactly INHIBIT_CYCLES cycles → RTS.
  - **RTS**: one cycle with clk_drive_low=1 and dat_drive_low=1 (start bit) → TX.
  - **TX**: clk_drive_low=0; dat_drive_low holds the start bit until the first fe.
    - On fe n (n=1..8), dat_drive_low = ~data[n-1] (LSB first).
    - On fe 9, dat_drive_low = ~parity.
    - On fe 10, dat_drive_low = 0 (stop bit, released) → ACK.
  - **ACK**: on the next fe, sample synchronised data; 0 = ack, 1 = ack_error → WAIT_IDLE.
  - **WAIT_IDLE**: wait until both synchronised lines are 1 → DONE.
  - **DONE**: pulse done with ack_error/timeout → IDLE.
- Bit counter is 4 bits, range 0..10; it cannot wrap because the state changes at 10.
- send while busy is ignored, not queued. send_data is don't-care outside the accepting cycle.
- Device clock edges seen in IDLE, INHIBIT or RTS are ignored.
- Asserting resetn mid-frame releases both lines at once and returns to IDLE. No done pulse is produced.

## Timing
- Reset values: ps2_clk_drive_low=0, ps2_dat_drive_low=0, busy=0, done=0, ack_error=0, timeout=0, state IDLE.
- Accepted send at cycle 0 → busy=1 and clk_drive_low=1 from cycle 1.
- Request-to-send: dat_drive_low rises at cycle INHIBIT_CYCLES+1; clk_drive_low falls at cycle INHIBIT_CYCLES+2.
- Pad-to-action latency: a data change or ack sample occurs 3 clk cycles after the pad falling edge (2 sync stages + edge register). This is far inside the PS/2 half-period of ≥30 µs.
- ack_error and timeout update on the done cycle and hold until the next accepted send.
- busy falls in the cycle after done; a new send is accepted in that same cycle.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to TX and on every fe.
  - In TX, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines and pulses done with timeout=1 and ack_error=1, then returns to IDLE.
- PS2_TX_TIMEOUT_EN undefined:
  - No counter is built; timeout is tied to 0.
  - A silent device holds the block in TX indefinitely; only reset recovers it.

## Structure
- Shared package ps2_pkg holds:
  - the state enum;
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_RESET=8'hFF;
  - response constant PS2_RESP_ACK=8'hFA;
  - default cycle counts for 50 MHz.
- Sub-module ps2_line_sync contains the two synchronisers and the fe detector. It is reusable by the receive path.

## Test plan
Bench uses INHIBIT_CYCLES=50 and TIMEOUT_CYCLES=1000, with a device model clocking at 12.5 kHz that samples data on rising edges.
- send 8'hED → device model decodes bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; model acks → one done pulse, ack_error=0, timeout=0, busy low afterwards.
- send 8'h01 → parity bit 0; send 8'h00 → parity bit 1; check the clk_drive_low pulse width is exactly 50 cycles followed by 1 RTS cycle.
- Device model leaves data high in the ack slot → done with ack_error=1, timeout=0.
- Second send pulse mid-frame carrying 8'hFF → ignored; the frame completes carrying the original byte, and only one done pulse occurs.
- With PS2_TX_TIMEOUT_EN, device never clocks → done with timeout=1 at cycle 50+2+1000 (±1), both drives 0. Without the macro, busy stays 1.
- resetn asserted after the 4th device edge → both drives 0 asynchronously, busy=0, no done pulse; the next send completes normally.
